addsub_serial: RTL and testbench

ADDSUB_SERIAL -- requirements
Module: addsub_serial

---
 rtl/addsub_serial.sv | 144 ++++++++++++++
 tb/tb_addsub_serial.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/addsub_serial.sv
// addsub_serial: chunk-serial two's-complement adder/subtractor.
//
// Operands are latched when start is seen. The sum is then built CHUNK bits
// per clock, LSB chunk first, over NCH = WIDTH/CHUNK cycles. The result
// outputs change only on the edge that enters DONE, so partial sums are
// never visible on sum/c_out/ovf.
//
// Ports
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   start  : begin an operation (honoured in IDLE and DONE)
//   sub    : 0 = a + b + c_in, 1 = a - b (c_in ignored)
//   a, b   : operands, WIDTH bits
//   c_in   : carry-in for add mode
//   busy   : high while chunks are being processed
//   done   : one-cycle pulse, results valid
//   sum    : result, WIDTH bits
//   c_out  : carry out of the MSB (in sub mode, 1 = no borrow)
//   ovf    : signed overflow
//
// state  | meaning
// IDLE   | waiting for start
// RUN    | adding one chunk per cycle
// DONE   | results just updated; done pulse; start here chains the next op

module addsub_serial #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;      // b already mapped to ~b in sub mode
  logic [WIDTH-1:0] r_acc;    // partial result, filled chunk by chunk
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;

  int               w_base;
  logic [CHUNK-1:0] w_a_ch;
  logic [CHUNK-1:0] w_b_ch;
  logic [CHUNK-1:0] w_s_ch;
  logic             w_c_ch;
  logic [WIDTH-1:0] w_acc_next;
  logic             w_load;
  logic             w_last;
  logic             w_c_msb_in;

  // Chunk adder
  always_comb begin
    w_base = int'(r_cnt) * CHUNK;
    w_a_ch = r_a[w_base +: CHUNK];
    w_b_ch = r_b[w_base +: CHUNK];
    {w_c_ch, w_s_ch} = {1'b0, w_a_ch} + {1'b0, w_b_ch} + {{CHUNK{1'b0}}, r_carry};
    w_acc_next = r_acc;
    w_acc_next[w_base +: CHUNK] = w_s_ch;
  end

  // On the last chunk, the carry into the MSB is recovered from the MSB sum
  // bit itself: s = a ^ b ^ cin  =>  cin = a ^ b ^ s.
  assign w_c_msb_in = r_a[WIDTH-1] ^ r_b[WIDTH-1] ^ w_s_ch[CHUNK-1];

  assign w_last = (r_cnt == LAST);
  assign w_load = start && ((r_state == S_IDLE) || (r_state == S_DONE));

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_DONE;
      S_DONE:  w_next = start ? S_RUN : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_load) begin
      r_a     <= a;
      r_b     <= sub ? ~b : b;
      r_carry <= sub ? 1'b1 : c_in;
      r_cnt   <= '0;
    end else if (r_state == S_RUN) begin
      r_acc   <= w_acc_next;
      r_carry <= w_c_ch;
      r_cnt   <= r_cnt + 1'b1;
      if (w_last) begin
        r_sum  <= w_acc_next;
        r_cout <= w_c_ch;
        r_ovf  <= w_c_ch ^ w_c_msb_in;
      end
    end
  end

  assign busy  = (r_state == S_RUN);
  assign done  = (r_state == S_DONE);
  assign sum   = r_sum;
  assign c_out = r_cout;
  assign ovf   = r_ovf;

endmodule

// File: tb/tb_addsub_serial.sv
module tb_addsub_serial;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 16-bit / 4-bit chunk instance
  logic        start = 1'b0, sub = 1'b0, c_in = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic        busy, done, c_out, ovf;
  logic [15:0] sum;

  // 8-bit / 8-bit chunk instance
  logic        start8 = 1'b0, sub8 = 1'b0, c_in8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8, c_out8, ovf8;
  logic [7:0]  sum8;

  addsub_serial #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b),
    .c_in(c_in), .busy(busy), .done(done), .sum(sum), .c_out(c_out), .ovf(ovf)
  );

  addsub_serial #(.WIDTH(8), .CHUNK(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub8), .a(a8), .b(b8),
    .c_in(c_in8), .busy(busy8), .done(done8), .sum(sum8), .c_out(c_out8), .ovf(ovf8)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        sub;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] sum;
    logic        c;
    logic        v;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic start_op(input logic s, input logic [15:0] xa, input logic [15:0] xb,
                          input logic ci);
    @(negedge clk);
    sub = s; a = xa; b = xb; c_in = ci; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at a negedge inside RUN; returns number of RUN cycles seen until done.
  task automatic wait_done(input string tag, output int n);
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      chk({tag, "_busy"}, {31'b0, busy}, 32'd1);
      @(negedge clk);
      n++;
    end
  endtask

  task automatic check_res(input string tag, input logic [15:0] es, input logic ec,
                           input logic ev);
    chk({tag, "_done"},  {31'b0, done},  32'd1);
    chk({tag, "_busy0"}, {31'b0, busy},  32'd0);
    chk({tag, "_sum"},   {16'b0, sum},   {16'b0, es});
    chk({tag, "_cout"},  {31'b0, c_out}, {31'b0, ec});
    chk({tag, "_ovf"},   {31'b0, ovf},   {31'b0, ev});
  endtask

  task automatic run_vec(input int i);
    int    n;
    string tag;
    tag = $sformatf("vec%0d", i);
    start_op(vecs[i].sub, vecs[i].a, vecs[i].b, vecs[i].cin);
    wait_done(tag, n);
    chk({tag, "_cycles"}, n, 32'd4);
    check_res(tag, vecs[i].sum, vecs[i].c, vecs[i].v);
    @(negedge clk);
    chk({tag, "_pulse"}, {31'b0, done}, 32'd0);
    chk({tag, "_idle"},  {31'b0, busy}, 32'd0);
    chk({tag, "_hold"},  {16'b0, sum},  {16'b0, vecs[i].sum});
  endtask

  initial begin
    int n;
    //          sub   a         b         cin   sum       c     v
    vecs[0] = '{1'b0, 16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[3] = '{1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[8] = '{1'b0, 16'h00FF, 16'h0F01, 1'b0, 16'h1000, 1'b0, 1'b0};
    vecs[9] = '{1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1};

    // Reset state
    #1;
    chk("rst_busy", {31'b0, busy},  32'd0);
    chk("rst_done", {31'b0, done},  32'd0);
    chk("rst_sum",  {16'b0, sum},   32'd0);
    chk("rst_cout", {31'b0, c_out}, 32'd0);
    chk("rst_ovf",  {31'b0, ovf},   32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) run_vec(i);

    // Operands and start toggled mid-RUN must not disturb the operation
    start_op(1'b1, 16'h0003, 16'h0005, 1'b1);
    a = 16'hAAAA; b = 16'h5555; sub = 1'b0; c_in = 1'b0;
    chk("mid_busy1", {31'b0, busy}, 32'd1);
    @(negedge clk);
    start = 1'b1;
    chk("mid_busy2", {31'b0, busy}, 32'd1);
    @(negedge clk);
    start = 1'b0;
    wait_done("mid", n);
    chk("mid_cycles", n + 2, 32'd4);
    check_res("mid", 16'hFFFE, 1'b0, 1'b0);

    // Back-to-back: start held through RUN and DONE
    @(negedge clk);
    sub = 1'b0; a = 16'h0001; b = 16'h0002; c_in = 1'b0; start = 1'b1;
    @(negedge clk);
    wait_done("b2b1", n);
    chk("b2b1_cycles", n, 32'd4);
    check_res("b2b1", 16'h0003, 1'b0, 1'b0);
    sub = 1'b1; a = 16'h0010; b = 16'h0001; c_in = 1'b0;
    @(negedge clk);
    chk("b2b_noidle_busy", {31'b0, busy}, 32'd1);
    chk("b2b_noidle_done", {31'b0, done}, 32'd0);
    start = 1'b0;
    wait_done("b2b2", n);
    chk("b2b2_cycles", n, 32'd4);
    check_res("b2b2", 16'h000F, 1'b1, 1'b0);

    // Leave nonzero outputs, then reset in the middle of RUN
    run_vec(9);
    start_op(1'b0, 16'h0001, 16'h0002, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'b0, busy},  32'd0);
    chk("abort_done", {31'b0, done},  32'd0);
    chk("abort_sum",  {16'b0, sum},   32'd0);
    chk("abort_cout", {31'b0, c_out}, 32'd0);
    chk("abort_ovf",  {31'b0, ovf},   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("abort_nodone", {31'b0, done}, 32'd0);
      chk("abort_idle",   {31'b0, busy}, 32'd0);
      chk("abort_nosum",  {16'b0, sum},  32'd0);
    end

    // Start honoured on the first edge after reset release
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    sub = 1'b0; a = 16'h0100; b = 16'h0023; c_in = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("post_rst_busy", {31'b0, busy}, 32'd1);
    wait_done("post_rst", n);
    chk("post_rst_cycles", n, 32'd4);
    check_res("post_rst", 16'h0124, 1'b0, 1'b0);

    // Single-chunk instance: WIDTH=8, CHUNK=8
    @(negedge clk);
    sub8 = 1'b0; a8 = 8'h7F; b8 = 8'h01; c_in8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    chk("w8_busy", {31'b0, busy8}, 32'd1);
    chk("w8_nodone", {31'b0, done8}, 32'd0);
    @(negedge clk);
    chk("w8_done", {31'b0, done8},  32'd1);
    chk("w8_sum",  {24'b0, sum8},   32'h80);
    chk("w8_cout", {31'b0, c_out8}, 32'd0);
    chk("w8_ovf",  {31'b0, ovf8},   32'd1);
    @(negedge clk);
    chk("w8_pulse", {31'b0, done8}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
